// File: rtl/cia_reg_arbiter.sv
// Two-port arbiter for the register bus of a single CIA (mos6526_8520).
// Port 0 (CPU) has priority. Each granted access is sequenced onto one phi2 cycle.
module cia_reg_arbiter #(
    parameter int STARVE_MAX  = 4,
    parameter bit PROTECT_ICR = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       phi2_p,
    input  logic       phi2_n,
    input  logic       m0_req,
    input  logic       m0_we,
    input  logic [3:0] m0_addr,
    input  logic [7:0] m0_wdata,
    output logic       m0_ack,
    output logic [7:0] m0_rdata,
    input  logic       m1_req,
    input  logic       m1_we,
    input  logic [3:0] m1_addr,
    input  logic [7:0] m1_wdata,
    output logic       m1_ack,
    output logic [7:0] m1_rdata,
    output logic       m1_err,
    output logic       cia_cs_n,
    output logic       cia_rw,
    output logic [3:0] cia_rs,
    output logic [7:0] cia_db_in,
    input  logic [7:0] cia_db_out,
    output logic       busy,
    output logic       grant_id
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [2:0] {IDLE, ARM, DRIVE, CAPT, REFUSE} state_t;

    state_t     state, state_nxt;
    logic       lat_we, we_nxt;
    logic [3:0] lat_addr, addr_nxt;
    logic [7:0] lat_wdata, wdata_nxt;
    logic [3:0] starve, starve_nxt;
    logic       grant_nxt, pick;
    logic       cs_n_nxt, rw_nxt;
    logic [3:0] rs_nxt;
    logic [7:0] db_in_nxt;
    logic       m0_ack_nxt, m1_ack_nxt, m1_err_nxt;
    logic [7:0] m0_rdata_nxt, m1_rdata_nxt;

    always_comb begin
        state_nxt    = state;
        we_nxt       = lat_we;
        addr_nxt     = lat_addr;
        wdata_nxt    = lat_wdata;
        starve_nxt   = starve;
        grant_nxt    = grant_id;
        pick         = 1'b0;
        cs_n_nxt     = cia_cs_n;
        rw_nxt       = cia_rw;
        rs_nxt       = cia_rs;
        db_in_nxt    = cia_db_in;
        m0_ack_nxt   = 1'b0;
        m1_ack_nxt   = 1'b0;
        m0_rdata_nxt = m0_rdata;
        m1_rdata_nxt = m1_rdata;
        m1_err_nxt   = m1_err;

        case (state)
            IDLE: begin
                // The ack cycle is a dead cycle so a held req re-arbitrates fresh next clk.
                if (!m0_ack && !m1_ack && (m0_req || m1_req)) begin
                    pick      = m1_req && (!m0_req || starve == STARVE_LIM);
                    grant_nxt = pick;
                    we_nxt    = pick ? m1_we    : m0_we;
                    addr_nxt  = pick ? m1_addr  : m0_addr;
                    wdata_nxt = pick ? m1_wdata : m0_wdata;
                    if (pick || !m1_req)
                        starve_nxt = 4'd0;
                    else if (starve != STARVE_LIM)
                        starve_nxt = starve + 4'd1;
                    if (PROTECT_ICR && pick && !m1_we && m1_addr == 4'hD)
                        state_nxt = REFUSE;
                    else
                        state_nxt = ARM;
                end
            end
            ARM: begin
                if (phi2_p) begin
                    cs_n_nxt  = 1'b0;
                    rw_nxt    = ~lat_we;
                    rs_nxt    = lat_addr;
                    db_in_nxt = lat_wdata;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (phi2_n) begin
                    cs_n_nxt  = 1'b1;
                    rw_nxt    = 1'b1;
                    state_nxt = CAPT;
                end
            end
            CAPT: begin
                if (grant_id) begin
                    m1_ack_nxt = 1'b1;
                    m1_err_nxt = 1'b0;
                    if (!lat_we)
                        m1_rdata_nxt = cia_db_out;
                end else begin
                    m0_ack_nxt = 1'b1;
                    m1_err_nxt = 1'b0;
                    if (!lat_we)
                        m0_rdata_nxt = cia_db_out;
                end
                state_nxt = IDLE;
            end
            REFUSE: begin
                m1_ack_nxt   = 1'b1;
                m1_err_nxt   = 1'b1;
                m1_rdata_nxt = 8'h00;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            starve    <= 4'd0;
            grant_id  <= 1'b0;
            busy      <= 1'b0;
            cia_cs_n  <= 1'b1;
            cia_rw    <= 1'b1;
            cia_rs    <= 4'd0;
            cia_db_in <= 8'd0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_rdata  <= 8'd0;
            m1_rdata  <= 8'd0;
            m1_err    <= 1'b0;
        end else begin
            state     <= state_nxt;
            starve    <= starve_nxt;
            grant_id  <= grant_nxt;
            busy      <= (state_nxt != IDLE);
            cia_cs_n  <= cs_n_nxt;
            cia_rw    <= rw_nxt;
            cia_rs    <= rs_nxt;
            cia_db_in <= db_in_nxt;
            m0_ack    <= m0_ack_nxt;
            m1_ack    <= m1_ack_nxt;
            m0_rdata  <= m0_rdata_nxt;
            m1_rdata  <= m1_rdata_nxt;
            m1_err    <= m1_err_nxt;
        end
    end

    // Latched request fields are pure data; state gates their use.
    always_ff @(posedge clk) begin
        lat_we    <= we_nxt;
        lat_addr  <= addr_nxt;
        lat_wdata <= wdata_nxt;
    end

endmodule

// File: tb/tb_cia_reg_arbiter.sv
// Directed bench for cia_reg_arbiter: instance "dut" protects ICR, "dut_b" does not.
// phi2 period is 8 clks: phi2_p in phase 0, phi2_n in phase 4.
module tb_cia_reg_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [2:0] ph = 3'd0;
    logic       phi2_p, phi2_n;
    always @(posedge clk) ph <= ph + 3'd1;
    assign phi2_p = (ph == 3'd0);
    assign phi2_n = (ph == 3'd4);

    logic       m0_req, m0_we, m1_req, m1_we;
    logic [3:0] m0_addr, m1_addr;
    logic [7:0] m0_wdata, m1_wdata;

    logic       m0_ack, m1_ack, m1_err, cia_cs_n, cia_rw, busy, grant_id;
    logic [7:0] m0_rdata, m1_rdata, cia_db_in;
    logic [3:0] cia_rs;
    logic [7:0] db_out = 8'h00;

    logic       m0_ack_b, m1_ack_b, m1_err_b, cia_cs_n_b, cia_rw_b, busy_b, grant_id_b;
    logic [7:0] m0_rdata_b, m1_rdata_b, cia_db_in_b;
    logic [3:0] cia_rs_b;
    logic [7:0] db_out_b = 8'h00;

    cia_reg_arbiter #(.STARVE_MAX(4), .PROTECT_ICR(1'b1)) dut (
        .clk(clk), .reset(reset), .phi2_p(phi2_p), .phi2_n(phi2_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .cia_cs_n(cia_cs_n), .cia_rw(cia_rw), .cia_rs(cia_rs), .cia_db_in(cia_db_in),
        .cia_db_out(db_out), .busy(busy), .grant_id(grant_id)
    );

    cia_reg_arbiter #(.STARVE_MAX(4), .PROTECT_ICR(1'b0)) dut_b (
        .clk(clk), .reset(reset), .phi2_p(phi2_p), .phi2_n(phi2_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack_b), .m0_rdata(m0_rdata_b),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack_b), .m1_rdata(m1_rdata_b), .m1_err(m1_err_b),
        .cia_cs_n(cia_cs_n_b), .cia_rw(cia_rw_b), .cia_rs(cia_rs_b), .cia_db_in(cia_db_in_b),
        .cia_db_out(db_out_b), .busy(busy_b), .grant_id(grant_id_b)
    );

    // CIA model: register reads return A1+rs, latched on the phi2_n clk.
    function automatic logic [7:0] rd_val(input logic [3:0] rs);
        return 8'hA1 + {4'h0, rs};
    endfunction

    logic [3:0] wr_rs = 4'h0;
    logic [7:0] wr_data = 8'h00;
    always @(posedge clk) begin
        if (phi2_n && !cia_cs_n) begin
            if (cia_rw) db_out <= rd_val(cia_rs);
            else begin
                wr_rs   <= cia_rs;
                wr_data <= cia_db_in;
            end
        end
        if (phi2_n && !cia_cs_n_b && cia_rw_b) db_out_b <= rd_val(cia_rs_b);
    end

    int errors = 0;
    int checks = 0;

    int         obs_cs_low, obs_cs_first, obs_ack_cyc, obs_ack_ph;
    logic       obs_strobe, obs_rw, obs_ack_port, obs_both, obs_err, obs_after;
    logic       obs_busy1, obs_busy_ack, obs_grant;
    logic [3:0] obs_rs;
    logic [7:0] obs_dbin, obs_rdata;

    task automatic wait_ph(input logic [2:0] p);
        @(negedge clk);
        while (ph != p) @(negedge clk);
    endtask

    // Runs one access on one port and records what the bus and handshake did.
    task automatic do_access(input logic port, input logic we, input logic [3:0] addr,
                             input logic [7:0] wdata, input logic [2:0] start_ph);
        wait_ph(start_ph);
        if (port) begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
        obs_cs_low = 0; obs_cs_first = -1; obs_ack_cyc = -1; obs_ack_ph = -1;
        obs_strobe = 1'b0; obs_rw = 1'bx; obs_rs = 4'hx; obs_dbin = 8'hxx;
        obs_ack_port = 1'bx; obs_both = 1'b0; obs_err = 1'bx; obs_rdata = 8'hxx;
        obs_busy1 = 1'bx; obs_busy_ack = 1'bx; obs_grant = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) obs_busy1 = busy;
            if (!cia_cs_n) begin
                obs_cs_low++;
                if (obs_cs_first < 0) obs_cs_first = c;
                if (phi2_n) begin
                    obs_strobe = 1'b1; obs_rw = cia_rw; obs_rs = cia_rs; obs_dbin = cia_db_in;
                end
            end
            if (m0_ack || m1_ack) begin
                obs_ack_cyc  = c;
                obs_ack_ph   = int'(ph);
                obs_ack_port = m1_ack;
                obs_both     = m0_ack && m1_ack;
                obs_rdata    = m1_ack ? m1_rdata : m0_rdata;
                obs_err      = m1_err;
                obs_busy_ack = busy;
                obs_grant    = grant_id;
                break;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
        obs_after = m0_ack || m1_ack;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 4'h0; m0_wdata = 8'h00;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 4'h0; m1_wdata = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({cia_cs_n, cia_rw, cia_rs, cia_db_in} !== {1'b1, 1'b1, 4'h0, 8'h00}) begin
            errors++;
            $display("FAIL reset_bus: got %0h expected %0h", {cia_cs_n, cia_rw, cia_rs, cia_db_in}, 14'h3000);
        end
        checks++;
        if ({m0_ack, m1_ack, m1_err, busy, grant_id} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {m0_ack, m1_ack, m1_err, busy, grant_id});
        end
        checks++;
        if ({m0_rdata, m1_rdata} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rdata: got %0h expected 0", {m0_rdata, m1_rdata});
        end
        checks++;
        if ({cia_cs_n_b, cia_rw_b, m0_ack_b, m1_ack_b, m1_err_b, busy_b, grant_id_b} !== 7'b1100000) begin
            errors++;
            $display("FAIL reset_b: got %b expected 1100000",
                     {cia_cs_n_b, cia_rw_b, m0_ack_b, m1_ack_b, m1_err_b, busy_b, grant_id_b});
        end
        reset = 1'b0;
    endtask

    task automatic test_m0_read();
        do_access(1'b0, 1'b0, 4'h4, 8'h00, 3'd5);
        checks++;
        if (obs_ack_cyc !== 9 || obs_ack_port !== 1'b0 || obs_after !== 1'b0) begin
            errors++;
            $display("FAIL t1_ack: got cyc=%0d port=%b after=%b expected cyc=9 port=0 after=0",
                     obs_ack_cyc, obs_ack_port, obs_after);
        end
        checks++;
        if (obs_cs_first !== 4 || obs_cs_low !== 4 || obs_strobe !== 1'b1) begin
            errors++;
            $display("FAIL t1_cs: got first=%0d low=%0d strobe=%b expected first=4 low=4 strobe=1",
                     obs_cs_first, obs_cs_low, obs_strobe);
        end
        checks++;
        if (obs_rw !== 1'b1 || obs_rs !== 4'h4) begin
            errors++;
            $display("FAIL t1_bus: got rw=%b rs=%0h expected rw=1 rs=4", obs_rw, obs_rs);
        end
        checks++;
        if (obs_rdata !== 8'hA5) begin
            errors++;
            $display("FAIL t1_rdata: got %0h expected a5", obs_rdata);
        end
        checks++;
        if (obs_busy1 !== 1'b1 || obs_busy_ack !== 1'b0 || obs_ack_ph !== 6) begin
            errors++;
            $display("FAIL t1_busy: got busy1=%b busy_ack=%b ack_ph=%0d expected 1 0 6",
                     obs_busy1, obs_busy_ack, obs_ack_ph);
        end
    endtask

    task automatic test_m1_write();
        do_access(1'b1, 1'b1, 4'hF, 8'h11, 3'd2);
        checks++;
        if (obs_ack_cyc !== 12 || obs_ack_port !== 1'b1 || obs_err !== 1'b0 || obs_both !== 1'b0) begin
            errors++;
            $display("FAIL t2_ack: got cyc=%0d port=%b err=%b both=%b expected cyc=12 port=1 err=0 both=0",
                     obs_ack_cyc, obs_ack_port, obs_err, obs_both);
        end
        checks++;
        if (obs_strobe !== 1'b1 || obs_rw !== 1'b0 || obs_rs !== 4'hF || obs_dbin !== 8'h11) begin
            errors++;
            $display("FAIL t2_strobe: got s=%b rw=%b rs=%0h db=%0h expected s=1 rw=0 rs=f db=11",
                     obs_strobe, obs_rw, obs_rs, obs_dbin);
        end
        checks++;
        if (wr_rs !== 4'hF || wr_data !== 8'h11) begin
            errors++;
            $display("FAIL t2_cia_write: got rs=%0h data=%0h expected rs=f data=11", wr_rs, wr_data);
        end
        checks++;
        if (obs_rdata !== 8'h00 || obs_grant !== 1'b1) begin
            errors++;
            $display("FAIL t2_keep: got rdata=%0h grant=%b expected rdata=0 grant=1", obs_rdata, obs_grant);
        end
    endtask

    task automatic test_starve();
        logic [9:0] seq;
        logic       rd_bad, pulse_bad, prev0, prev1;
        int         n;
        seq = 10'h0; rd_bad = 1'b0; pulse_bad = 1'b0; prev0 = 1'b0; prev1 = 1'b0; n = 0;
        wait_ph(3'd1);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 4'h2;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 4'h3;
        for (int c = 0; c < 400 && n < 10; c++) begin
            @(negedge clk);
            if ((m0_ack && prev0) || (m1_ack && prev1) || (m0_ack && m1_ack)) pulse_bad = 1'b1;
            prev0 = m0_ack; prev1 = m1_ack;
            if (m0_ack || m1_ack) begin
                seq[n] = m1_ack;
                if (m0_ack && m0_rdata !== 8'hA3) rd_bad = 1'b1;
                if (m1_ack && m1_rdata !== 8'hA4) rd_bad = 1'b1;
                n++;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        checks++;
        if (seq !== 10'b10000_10000) begin
            errors++;
            $display("FAIL t3_grant_seq: got %b (n=%0d) expected 1000010000 (bit0 first)", seq, n);
        end
        checks++;
        if (pulse_bad !== 1'b0) begin
            errors++;
            $display("FAIL t3_ack_pulse: got %b expected 0", pulse_bad);
        end
        checks++;
        if (rd_bad !== 1'b0) begin
            errors++;
            $display("FAIL t3_rdata: got %b expected 0", rd_bad);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_icr_protect();
        int a_cyc, b_cyc, cs_seen;
        logic a_err, b_err;
        logic [7:0] a_rd, b_rd;
        a_cyc = -1; b_cyc = -1; cs_seen = 0;
        a_err = 1'bx; b_err = 1'bx; a_rd = 8'hxx; b_rd = 8'hxx;
        wait_ph(3'd2);
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 4'hD; m1_wdata = 8'h00;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!cia_cs_n) cs_seen++;
            if (m1_ack && a_cyc < 0) begin
                a_cyc = c; a_err = m1_err; a_rd = m1_rdata;
            end
            if (m1_ack_b) begin
                b_cyc = c; b_err = m1_err_b; b_rd = m1_rdata_b;
                break;
            end
        end
        m1_req = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (!cia_cs_n) cs_seen++;
        end
        checks++;
        if (a_cyc !== 2 || a_err !== 1'b1 || a_rd !== 8'h00) begin
            errors++;
            $display("FAIL t4_refuse: got cyc=%0d err=%b rdata=%0h expected cyc=2 err=1 rdata=0",
                     a_cyc, a_err, a_rd);
        end
        checks++;
        if (cs_seen !== 0) begin
            errors++;
            $display("FAIL t4_no_cs: got %0d low clks expected 0", cs_seen);
        end
        checks++;
        if (b_cyc !== 12 || b_err !== 1'b0 || b_rd !== 8'hAE) begin
            errors++;
            $display("FAIL t4_unprotected: got cyc=%0d err=%b rdata=%0h expected cyc=12 err=0 rdata=ae",
                     b_cyc, b_err, b_rd);
        end
    endtask

    task automatic test_reset_mid();
        logic found, got;
        logic [7:0] rd;
        int cs_low;
        found = 1'b0; got = 1'b0; rd = 8'hxx; cs_low = 0;
        wait_ph(3'd6);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 4'h7;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!cia_cs_n) begin
                found = 1'b1;
                break;
            end
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (found !== 1'b1 || cia_cs_n !== 1'b1 || busy !== 1'b0 || m0_ack !== 1'b0) begin
            errors++;
            $display("FAIL t5_reset_drive: got found=%b cs_n=%b busy=%b ack=%b expected 1 1 0 0",
                     found, cia_cs_n, busy, m0_ack);
        end
        reset = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!cia_cs_n) cs_low++;
            if (m0_ack) begin
                got = 1'b1; rd = m0_rdata;
                break;
            end
        end
        m0_req = 1'b0;
        checks++;
        if (got !== 1'b1 || rd !== 8'hA8 || cs_low !== 4) begin
            errors++;
            $display("FAIL t5_after_reset: got ack=%b rdata=%0h cs_low=%0d expected 1 a8 4", got, rd, cs_low);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_grant_on_phi2p();
        do_access(1'b0, 1'b0, 4'h9, 8'h00, 3'd0);
        checks++;
        if (obs_cs_first !== 9 || obs_cs_low !== 4) begin
            errors++;
            $display("FAIL t6_skip_pulse: got first=%0d low=%0d expected first=9 low=4", obs_cs_first, obs_cs_low);
        end
        checks++;
        if (obs_ack_cyc !== 14 || obs_rdata !== 8'hAA) begin
            errors++;
            $display("FAIL t6_ack: got cyc=%0d rdata=%0h expected cyc=14 rdata=aa", obs_ack_cyc, obs_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_m0_read();
        test_m1_write();
        test_starve();
        test_icr_protect();
        test_reset_mid();
        test_grant_on_phi2p();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
